// File: rtl/ring_osc_meter.sv
// ring_osc_meter: gated ring-oscillator edge counter with settle, abort and saturation
module ring_osc_meter #(
    parameter int GATE_W        = 16,
    parameter int COUNT_W       = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [GATE_W-1:0]  gate_cycles,
    input  logic               osc_in,
    output logic               osc_en,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [COUNT_W-1:0] CMAX = '1;
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, FINISH} state_t;
    state_t               r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_prev;
    logic [GATE_W-1:0]    r_gate_cnt;
    logic [SW-1:0]        r_settle_cnt;
    logic [COUNT_W-1:0]   r_run_cnt;
    logic                 r_sticky;
    logic                 w_rise;
    logic                 w_inc;
    logic [COUNT_W-1:0]   w_run_nxt;
    logic                 w_sticky_nxt;
    // bring the asynchronous oscillator into clk and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end
    // next running-count value: only rises inside the gate count, and the counter holds at full scale
    always_comb begin
        w_rise       = r_sync[SYNC_STAGES-1] & ~r_prev;
        w_inc        = (r_state == MEASURE) && w_rise && (r_run_cnt != CMAX);
        w_run_nxt    = r_run_cnt + COUNT_W'(w_inc);
        w_sticky_nxt = r_sticky | (w_run_nxt == CMAX);
    end
    // measurement sequencer; outputs are loaded on state entry so they line up with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gate_cnt   <= '0;
            r_settle_cnt <= '0;
            r_run_cnt    <= '0;
            r_sticky     <= 1'b0;
            osc_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            done      <= 1'b0;
            r_run_cnt <= w_run_nxt;
            r_sticky  <= w_sticky_nxt;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_gate_cnt <= gate_cycles;
                        r_run_cnt  <= '0;
                        r_sticky   <= 1'b0;
                        busy       <= 1'b1;
                        if (gate_cycles == '0) begin
                            r_state  <= FINISH;
                            done     <= 1'b1;
                            count    <= '0;
                            overflow <= 1'b0;
                        end else begin
                            r_state      <= SETTLE;
                            osc_en       <= 1'b1;
                            r_settle_cnt <= SW'(SETTLE_CYCLES - 1);
                        end
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        osc_en  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (r_settle_cnt == '0) begin
                        r_state <= MEASURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        osc_en  <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt - 1'b1;
                        if (r_gate_cnt == GATE_W'(1)) begin
                            r_state  <= FINISH;
                            osc_en   <= 1'b0;
                            done     <= 1'b1;
                            count    <= w_run_nxt;
                            overflow <= w_sticky_nxt;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ring_osc_meter.md
Name: ring_osc_meter

Overview:
- Measurement controller for the on-chip ring oscillator. On request it enables the oscillator, lets it settle, then counts oscillator rising edges over a programmable gate of system-clock cycles. It then disables the oscillator and reports the count.
- Sits between the design's control logic and the ring oscillator's en/clk_out pins. The oscillator runs only while a measurement is in progress.

Parameters:
- GATE_W, 16, width of the gate-length input (system-clock cycles).
- COUNT_W, 16, width of the edge-count result; the count saturates at 2^COUNT_W-1.
- SYNC_STAGES, 2, number of flops synchronising osc_in into clk (minimum 2).
- SETTLE_CYCLES, 4, cycles osc_en is held high before counting starts; must be >= SYNC_STAGES+1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a measurement; sampled only in IDLE.
- abort  input  1  cancel an in-progress measurement.
- gate_cycles  input  GATE_W  gate length in clk cycles; latched on accepted start.
- osc_in  input  1  ring oscillator output; asynchronous to clk.
- osc_en  output  1  ring oscillator enable.
- busy  output  1  high from the cycle after an accepted start until done (inclusive).
- done  output  1  one-cycle pulse when count/overflow become valid.
- count  output  COUNT_W  rising edges counted in the last completed measurement.
- overflow  output  1  the last completed measurement saturated count.

Behaviour:
- Reset (rst=1 at a clk edge) forces the following; all other state is cleared:
  - FSM to IDLE;
  - osc_en=0, busy=0, done=0, count=0, overflow=0;
  - synchroniser and edge-detect flops to 0.
- Synchroniser: osc_in passes through SYNC_STAGES flops, then one more "prev" flop, every cycle in every state. rise = sync_out & ~prev.
- Outputs are registered; the state names below describe register contents.
- IDLE (osc_en=0, busy=0):
  - start=1 latches gate_cycles into gate_cnt and clears the running counter and sticky overflow.
  - If gate_cycles==0, go to FINISH. Otherwise go to SETTLE with settle_cnt=SETTLE_CYCLES-1.
- SETTLE (osc_en=1, busy=1):
  - Rises are ignored. settle_cnt decrements each cycle.
  - At 0, go to MEASURE.
- MEASURE (osc_en=1, busy=1):
  - Each cycle with rise=1 increments the running counter.
  - On reaching 2^COUNT_W-1 the counter holds and sticky overflow sets.
  - gate_cnt decrements each cycle; the cycle gate_cnt==1 is the last counted cycle, then go to FINISH.
  - MEASURE lasts exactly gate_cycles cycles.
- FINISH (osc_en=0, busy=1, done=1 for exactly this cycle):
  - count and overflow are loaded from the running counter and sticky flag.
  - Next state is IDLE.
- Timing: start accepted at edge T gives:
  - osc_en high for cycles T+1 .. T+SETTLE_CYCLES+G;
  - done at T+SETTLE_CYCLES+G+1;
  - busy low again at T+SETTLE_CYCLES+G+2.
  - When G=0: done at T+1 and osc_en never rises.
- count and overflow hold their values between measurements. They change only in FINISH or on reset.
- start while busy is ignored and not queued. start is also ignored in the FINISH cycle; the next start is accepted in IDLE.
- abort in SETTLE or MEASURE:
  - next cycle IDLE, osc_en=0, busy=0;
  - no done pulse;
  - count and overflow keep their previous values.
  - abort in IDLE or FINISH has no effect. abort and start together in IDLE: abort wins and start is ignored.
- rst mid-measurement behaves as reset: osc_en drops on the next edge.
- Accuracy note: counting is exact only if the oscillator period is > 2 clk periods. Faster oscillators undercount. overflow does not detect this.

Test Plan:
- Reset: hold rst 3 cycles with start=1 → osc_en=busy=done=count=overflow=0, FSM IDLE; release rst with start=0 → still idle.
- Nominal: bench toggles osc_in every 2 clk (period 4 clk), start with gate_cycles=100, defaults → osc_en high exactly 104 cycles, done one cycle at T+105, count=25, overflow=0, busy low at T+106.
- Saturation: COUNT_W=4, osc_in toggles every 3 clk, gate_cycles=200 → count=15, overflow=1; next run with gate_cycles=12 → count=2, overflow=0.
- Zero gate: gate_cycles=0 → done at T+1, count=0, osc_en never asserted.
- Abort and ignored start:
  - start gate_cycles=50, pulse start again at T+10 → no restart;
  - abort at T+20 → osc_en=0 and busy=0 at T+21, no done, count unchanged from previous run.
- Reset mid-run: rst at T+30 of a 100-cycle gate → all outputs 0 next cycle; a fresh start then completes normally with the correct count.
